mdc_bf2_stage: RTL and testbench
================================

Name: mdc_bf2_stage

Overview:
- Radix-2 DIF butterfly stage of the multi-path delay-commutator FFT pipeline.
- Sits directly upstream of the stage's commutator (reorder) and consumes the two lanes produced by the previous commutator.
- Computes upper = (a+b)/2 and lower = ((a-b)/2)·W^idx, with the twiddle sequenced internally from a sample counter.
- Also generates the sw control for the downstream commutator, aligned to its own output stream.

Parameters:
- FFT_LEN, 16: transform length N; power of two, >= 4.
- STAGE, 0: stage index, 0 .. log2(N)-1.
- TW_W, 16: twiddle width, signed; scale 2^(TW_W-2).
- Derived: BLOCK = FFT_LEN >> (STAGE+1); SW_PERIOD = BLOCK/2.
- Data width is fft_pkg::DATA_W. complex_t = {re, im}, each signed DATA_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sync_clr  in  1  synchronous clear of twiddle and sw counters
- din_a  in  complex_t  upper lane
- din_b  in  complex_t  lower lane
- din_valid  in  1  lanes valid this cycle
- dout_a  out  complex_t  sum lane
- dout_b  out  complex_t  twiddled difference lane
- dout_valid  out  1  outputs valid
- sw_out  out  1  commutator control for downstream reorder

Behaviour:
- Reset:
  - one clk, reset asynchronous active-low (rst_n).
  - rst_n=0 clears all pipeline registers, the valid pipe, both counters and sw_out to 0.
  - Mid-frame reset discards in-flight samples; no dout_valid is issued for them.
- Latency: fixed 3 cycles, din_valid to dout_valid. No backpressure; every valid input produces exactly one valid output.
- P1 (register):
  - sum = (a+b)>>>1 and diff = (a-b)>>>1, computed at DATA_W+1 bits; arithmetic shift, result fits DATA_W.
  - Fetch twiddle W[idx] from the ROM.
- P2 (register): four products diff.re·W.re, diff.im·W.im, diff.re·W.im, diff.im·W.re at DATA_W+TW_W bits.
- P3 (register):
  - re = rr - ii; im = ri + ir.
  - Add 2^(TW_W-3), then >>> (TW_W-2) (round half up).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - The upper lane is delayed to match.
- Twiddle ROM:
  - FFT_LEN/2 entries, built at elaboration.
  - W[m] = round(cos(2πm/N)·S) + j·round(-sin(2πm/N)·S), with S = 2^(TW_W-2).
- Twiddle index:
  - k counts accepted din_valid samples mod BLOCK; idx = k << STAGE.
  - k holds during gaps; wraps BLOCK-1 -> 0.
  - Last stage (BLOCK = 1): idx is always 0.
- sw_out:
  - An output-side counter counts dout_valid mod SW_PERIOD.
  - sw_out toggles on the cycle after the dout_valid that completes each SW_PERIOD group.
  - If SW_PERIOD < 1, sw_out is held at 0.
- sync_clr:
  - Zeroes k and the output counter, and clears sw_out.
  - The pipeline data and valid pipe are not flushed.
  - If sync_clr coincides with din_valid, that sample uses idx 0 and the next sample uses k = 1.
- Invalid cycles: data registers may load don't-care values; only qualified by dout_valid.

Test Plan (all scenarios: N=16, STAGE=0, DATA_W=16, TW_W=16, S=16384):
- Reset: assert rst_n=0 mid-stream with valid data in flight -> dout_valid, dout_a, dout_b, sw_out = 0 immediately; no stale valid after release.
- k=0: a=(1000,0), b=(0,0) -> 3 cycles later dout_a=(500,0), dout_b=(500,0), dout_valid=1 for one cycle.
- k=4 (W=(0,-16384)): a=(1000,0), b=0 at 5th valid sample -> dout_b=(0,-500).
- k=2 (W=(11585,-11585)): a=(2000,0), b=0 -> dout_b=(707,-707).
- Saturation, k=1 (W=(15137,-6270)): a=(32767,32767), b=(-32768,-32768) -> dout_b=(32767,17733).
- Stream/sequencing: 16 valid samples with a 1-cycle bubble between each -> idx sequence 0..7,0..7; sw_out toggles after output valids 4, 8, 12, 16. Asserting sync_clr at sample 3 restarts idx at 0.

Source files
------------

// File: rtl/mdc_bf2_stage.sv
// ---------------------------------------------------------------------------
// fft_pkg : shared data width and complex sample type for the MDC FFT.
// mdc_bf2_stage : radix-2 DIF butterfly stage of the multi-path
// delay-commutator FFT pipeline.
//   upper = (a+b)/2, lower = ((a-b)/2) * W^idx, fixed 3-cycle latency.
//   The twiddle index is sequenced from a count of accepted input samples.
//   The commutator control for the downstream reorder is derived from a
//   count of output samples.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   sync_clr   synchronous clear of the twiddle and sw counters
//   din_a      upper input lane (complex_t)
//   din_b      lower input lane (complex_t)
//   din_valid  both input lanes valid this cycle
//   dout_a     sum lane
//   dout_b     twiddled difference lane
//   dout_valid outputs valid
//   sw_out     commutator control for the downstream reorder
// ---------------------------------------------------------------------------
package fft_pkg;
    localparam int unsigned DATA_W = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;
endpackage

module mdc_bf2_stage
    import fft_pkg::*;
#(
    parameter int unsigned FFT_LEN = 16,
    parameter int unsigned STAGE   = 0,
    parameter int unsigned TW_W    = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     sync_clr,
    input  complex_t din_a,
    input  complex_t din_b,
    input  logic     din_valid,
    output complex_t dout_a,
    output complex_t dout_b,
    output logic     dout_valid,
    output logic     sw_out
);

    localparam int unsigned BLOCK     = FFT_LEN >> (STAGE + 1);
    localparam int unsigned SW_PERIOD = BLOCK / 2;
    localparam int unsigned ROM_N     = FFT_LEN / 2;
    localparam int unsigned IDX_W     = $clog2(ROM_N);
    localparam int unsigned K_W       = (BLOCK > 1) ? $clog2(BLOCK) : 1;
    localparam int unsigned C_W       = (SW_PERIOD > 1) ? $clog2(SW_PERIOD) : 1;
    localparam int unsigned PROD_W    = DATA_W + TW_W;
    localparam int unsigned ACC_W     = PROD_W + 1;

    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = real'(1 << (TW_W - 2));

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (TW_W - 3));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));

    // -----------------------------------------------------------------------
    // Twiddle ROM, W[m] = cos(2*pi*m/N) - j*sin(2*pi*m/N), scaled and rounded
    // half away from zero at elaboration.
    // -----------------------------------------------------------------------
    logic signed [TW_W-1:0] rom_re [ROM_N];
    logic signed [TW_W-1:0] rom_im [ROM_N];

    for (genvar m = 0; m < ROM_N; m++) begin : g_rom
        localparam real ANG  = 2.0 * PI * real'(m) / real'(FFT_LEN);
        localparam real RE_R = $cos(ANG) * SCALE;
        localparam real IM_R = -$sin(ANG) * SCALE;
        localparam int  RE_I = (RE_R >= 0.0) ? $rtoi(RE_R + 0.5) : -$rtoi(0.5 - RE_R);
        localparam int  IM_I = (IM_R >= 0.0) ? $rtoi(IM_R + 0.5) : -$rtoi(0.5 - IM_R);
        assign rom_re[m] = TW_W'(RE_I);
        assign rom_im[m] = TW_W'(IM_I);
    end

    // (x +/- y) >>> 1 evaluated one bit wider so the halved result always fits
    function automatic logic signed [DATA_W-1:0] half_op(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y,
        input logic                     sub
    );
        logic signed [DATA_W:0] t;
        t = sub ? ((DATA_W+1)'(x) - (DATA_W+1)'(y)) : ((DATA_W+1)'(x) + (DATA_W+1)'(y));
        return DATA_W'(t >>> 1);
    endfunction

    // round half up, drop the twiddle scale, clamp to the data range
    function automatic logic signed [DATA_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] x
    );
        logic signed [ACC_W-1:0] r;
        r = (x + RND) >>> (TW_W - 2);
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        return DATA_W'(r);
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [K_W-1:0]  k_q,    k_d;
    logic [C_W-1:0]  ocnt_q, ocnt_d;
    logic            sw_q,   sw_d;
    logic            v1_q, v2_q, v3_q;

    complex_t               sum1_q,  sum1_d;
    complex_t               diff1_q, diff1_d;
    logic signed [TW_W-1:0] twr_q,   twr_d;
    logic signed [TW_W-1:0] twi_q,   twi_d;

    complex_t                 sum2_q;
    logic signed [PROD_W-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [PROD_W-1:0] rr_d, ii_d, ri_d, ir_d;

    complex_t oa_q;
    complex_t ob_q, ob_d;

    logic [K_W-1:0]   k_eff;
    logic [IDX_W-1:0] idx;

    // -----------------------------------------------------------------------
    // Input-side sample counter and twiddle index. A sync_clr coinciding with
    // a valid sample makes that sample use index 0 and the next one k = 1.
    // -----------------------------------------------------------------------
    always_comb begin
        k_eff = sync_clr ? '0 : k_q;
        idx   = IDX_W'(k_eff) << STAGE;
        k_d   = k_q;
        if (sync_clr) begin
            k_d = '0;
        end
        if (din_valid) begin
            k_d = (k_eff == K_W'(BLOCK - 1)) ? '0 : k_eff + K_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------
    always_comb begin
        sum1_d.re  = half_op(din_a.re, din_b.re, 1'b0);
        sum1_d.im  = half_op(din_a.im, din_b.im, 1'b0);
        diff1_d.re = half_op(din_a.re, din_b.re, 1'b1);
        diff1_d.im = half_op(din_a.im, din_b.im, 1'b1);
        twr_d      = rom_re[idx];
        twi_d      = rom_im[idx];

        rr_d = PROD_W'(diff1_q.re) * PROD_W'(twr_q);
        ii_d = PROD_W'(diff1_q.im) * PROD_W'(twi_q);
        ri_d = PROD_W'(diff1_q.re) * PROD_W'(twi_q);
        ir_d = PROD_W'(diff1_q.im) * PROD_W'(twr_q);

        ob_d.re = round_sat(ACC_W'(rr_q) - ACC_W'(ii_q));
        ob_d.im = round_sat(ACC_W'(ri_q) + ACC_W'(ir_q));
    end

    // -----------------------------------------------------------------------
    // Output-side counter: sw toggles the cycle after the output that
    // completes each SW_PERIOD group. Held at 0 when SW_PERIOD is 0.
    // -----------------------------------------------------------------------
    always_comb begin
        ocnt_d = ocnt_q;
        sw_d   = sw_q;
        if (sync_clr) begin
            ocnt_d = '0;
            sw_d   = 1'b0;
        end else if (v3_q && (SW_PERIOD != 0)) begin
            if (ocnt_q == C_W'(SW_PERIOD - 1)) begin
                ocnt_d = '0;
                sw_d   = ~sw_q;
            end else begin
                ocnt_d = ocnt_q + C_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            ocnt_q  <= '0;
            sw_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            sum1_q  <= '0;
            diff1_q <= '0;
            twr_q   <= '0;
            twi_q   <= '0;
            sum2_q  <= '0;
            rr_q    <= '0;
            ii_q    <= '0;
            ri_q    <= '0;
            ir_q    <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
        end else begin
            k_q     <= k_d;
            ocnt_q  <= ocnt_d;
            sw_q    <= sw_d;
            v1_q    <= din_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            sum1_q  <= sum1_d;
            diff1_q <= diff1_d;
            twr_q   <= twr_d;
            twi_q   <= twi_d;
            sum2_q  <= sum1_q;
            rr_q    <= rr_d;
            ii_q    <= ii_d;
            ri_q    <= ri_d;
            ir_q    <= ir_d;
            oa_q    <= sum2_q;
            ob_q    <= ob_d;
        end
    end

    assign dout_a     = oa_q;
    assign dout_b     = ob_q;
    assign dout_valid = v3_q;
    assign sw_out     = sw_q;

endmodule

// File: tb/tb_mdc_bf2_stage.sv
// ---------------------------------------------------------------------------
// Testbench for mdc_bf2_stage (N=16, STAGE=0, TW_W=16).
// Directed vectors with known results, sequencing runs and randomized
// traffic are checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mdc_bf2_stage;
    import fft_pkg::*;

    localparam int N     = 16;
    localparam int ST    = 0;
    localparam int TWW   = 16;
    localparam int BLOCK = N >> (ST + 1);
    localparam int SWP   = BLOCK / 2;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     sync_clr;
    complex_t din_a, din_b;
    logic     din_valid;
    complex_t dout_a, dout_b;
    logic     dout_valid;
    logic     sw_out;

    mdc_bf2_stage #(.FFT_LEN(N), .STAGE(ST), .TW_W(TWW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clr   (sync_clr),
        .din_a      (din_a),
        .din_b      (din_b),
        .din_valid  (din_valid),
        .dout_a     (dout_a),
        .dout_b     (dout_b),
        .dout_valid (dout_valid),
        .sw_out     (sw_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int ar, ai, br, bi;
        bit has_c;
        int car, cai, cbr, cbi;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ecount   = 0;
    int   k_m      = 0;
    int   cnt_m    = 0;
    bit   sw_m     = 1'b0;
    bit   prev_v   = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic complex_t mk(input int r, input int i);
        complex_t c;
        c.re = 16'(r);
        c.im = 16'(i);
        return c;
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(0.5 - x));
    endfunction

    function automatic int sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    // expected outputs from the butterfly definition with exact arithmetic
    function automatic exp_t model(input complex_t a, input complex_t b, input int idx);
        exp_t   e;
        int     dr, di, wr, wi;
        real    ang;
        longint pre, pim;
        ang  = 2.0 * 3.14159265358979323846 * real'(idx) / real'(N);
        wr   = rnd($cos(ang) * 16384.0);
        wi   = rnd(-$sin(ang) * 16384.0);
        e.ar = (int'(a.re) + int'(b.re)) >>> 1;
        e.ai = (int'(a.im) + int'(b.im)) >>> 1;
        dr   = (int'(a.re) - int'(b.re)) >>> 1;
        di   = (int'(a.im) - int'(b.im)) >>> 1;
        pre  = longint'(dr) * wr - longint'(di) * wi + 8192;
        pim  = longint'(dr) * wi + longint'(di) * wr + 8192;
        e.br = sat16(pre >>> 14);
        e.bi = sat16(pim >>> 14);
        e.has_c = 1'b0;
        e.car = 0; e.cai = 0; e.cbr = 0; e.cbi = 0;
        e.due = 0;
        return e;
    endfunction

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cyc(input bit v, input complex_t a, input complex_t b, input bit clr,
                       input bit has_c, input int car, input int cai,
                       input int cbr, input int cbi);
        exp_t e;
        bit   exp_v;
        int   idx;
        din_valid = v;
        din_a     = a;
        din_b     = b;
        sync_clr  = clr;
        ecount++;
        if (clr) begin
            cnt_m = 0;
            sw_m  = 1'b0;
        end else if (prev_v && SWP > 0) begin
            cnt_m++;
            if (cnt_m == SWP) begin
                cnt_m = 0;
                sw_m  = ~sw_m;
            end
        end
        if (v) begin
            idx     = clr ? 0 : k_m;
            e       = model(a, b, idx << ST);
            e.due   = ecount + 2;
            e.has_c = has_c;
            e.car = car; e.cai = cai; e.cbr = cbr; e.cbi = cbi;
            q.push_back(e);
            k_m = (idx + 1) % BLOCK;
        end else if (clr) begin
            k_m = 0;
        end
        @(posedge clk);
        #1;
        exp_v = (q.size() > 0) && (q[0].due == ecount);
        chk("valid", dout_valid, exp_v);
        chk("sw", sw_out, sw_m);
        if (exp_v) begin
            e = q.pop_front();
            chk("a_re", dout_a.re, e.ar);
            chk("a_im", dout_a.im, e.ai);
            chk("b_re", dout_b.re, e.br);
            chk("b_im", dout_b.im, e.bi);
            if (e.has_c) begin
                chk("const_a_re", dout_a.re, e.car);
                chk("const_a_im", dout_a.im, e.cai);
                chk("const_b_re", dout_b.re, e.cbr);
                chk("const_b_im", dout_b.im, e.cbi);
            end
        end
        prev_v = exp_v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic clr_cycle();
        cyc(1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic rnd_sample(input bit clr);
        cyc(1'b1, mk($urandom, $urandom), mk($urandom, $urandom), clr, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic reset_model();
        q.delete();
        k_m    = 0;
        cnt_m  = 0;
        sw_m   = 1'b0;
        prev_v = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_a"}, dout_a, 0);
        chk({tag, "_b"}, dout_b, 0);
        chk({tag, "_sw"}, sw_out, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        sync_clr  = 1'b0;
        din_valid = 1'b0;
        din_a     = mk(0, 0);
        din_b     = mk(0, 0);
        #1;
        check_zero_outputs("reset");
        @(posedge clk); ecount++;
        @(posedge clk); ecount++;
        #1;
        rst_n = 1'b1;
        reset_model();
        idle(2);

        // k=0: W=1
        clr_cycle();
        cyc(1'b1, mk(1000, 0), mk(0, 0), 1'b0, 1'b1, 500, 0, 500, 0);
        idle(4);

        // k=0..4 with saturation at k=1, W^2 at k=2 and -j at k=4
        clr_cycle();
        rnd_sample(1'b0);
        cyc(1'b1, mk(32767, 32767), mk(-32768, -32768), 1'b0, 1'b1, -1, -1, 32767, 17733);
        cyc(1'b1, mk(2000, 0), mk(0, 0), 1'b0, 1'b1, 1000, 0, 707, -707);
        rnd_sample(1'b0);
        cyc(1'b1, mk(1000, 0), mk(0, 0), 1'b0, 1'b1, 500, 0, 0, -500);
        idle(5);

        // 16 samples with a bubble after each: idx 0..7,0..7, sw toggles per 4 outputs
        clr_cycle();
        for (int i = 0; i < 16; i++) begin
            rnd_sample(1'b0);
            idle(1);
        end
        idle(5);

        // same stream with sync_clr on sample 3
        clr_cycle();
        for (int i = 0; i < 16; i++) begin
            rnd_sample(i == 3);
            idle(1);
        end
        idle(5);

        // randomized traffic with occasional sync_clr
        for (int i = 0; i < 500; i++) begin
            bit v, c;
            v = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 49) == 0);
            if (v) rnd_sample(c);
            else   cyc(1'b0, mk(0, 0), mk(0, 0), c, 1'b0, 0, 0, 0, 0);
        end

        // mid-stream reset with samples in flight
        for (int i = 0; i < 3; i++) rnd_sample(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        reset_model();
        din_valid = 1'b0;
        @(posedge clk); ecount++;
        @(posedge clk); ecount++;
        #1;
        rst_n = 1'b1;
        idle(6);

        // traffic resumes with idx from 0 after reset
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) rnd_sample(1'b0);
            else idle(1);
        end
        idle(6);
        chk("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
